echo_app_stats_sampler: RTL and testbench
=========================================

# echo_app_stats_sampler

Upstream producer for the echo app stats log. Counts completed echo requests from `echo_app_incr_req_done`. Every `SAMPLE_INTERVAL` cycles it emits one `echo_app_stats_struct` record (timestamp plus request count) as a single-cycle write into the simple_log write port. Sampling starts at the first completed request, so the log never fills with idle zero records.

## Interface
- `SAMPLE_INTERVAL`, 1024: cycles per sample; legal range 2..2^32-1 (elaboration error otherwise).
- `CNT_W`, 32: internal request-counter width; must be ≤ `STATS_REQ_CNT_W` (elaboration error otherwise).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `echo_app_incr_req_done` in 1: one-cycle pulse per completed request; may be high on consecutive cycles.
- `log_wr_req_val` out 1: record write strobe. Registered. No backpressure: the log accepts every cycle.
- `log_wr_req_data` out `ECHO_APP_STATS_STRUCT_W`: record `{timestamp, req_cnt}`. Registered. Valid only while `log_wr_req_val` is high.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
- IDLE → RUN on a cycle with `echo_app_incr_req_done`=1. At that edge:
  - `req_cnt`←1
  - `interval_cnt`←0
  - `timestamp`←0
- RUN has no exit except reset.
- In RUN, every cycle:
  - `timestamp` increments, wrapping at 2^`STATS_TIMESTAMP_W`.
  - `interval_cnt` increments, wrapping from `SAMPLE_INTERVAL`-1 to 0.
- Tick: RUN cycle with `interval_cnt`==`SAMPLE_INTERVAL`-1. At the tick edge:
  - `log_wr_req_val`←1.
  - `log_wr_req_data.timestamp` ← current `timestamp`.
  - `log_wr_req_data.req_cnt` ← zero-extended count, including any request completing in the tick cycle itself.
- `req_cnt` saturates at 2^`CNT_W`-1 and never wraps.
- Simultaneous request and tick: the request is counted in the record being closed.
- No records are written in IDLE.

## Timing
- Reset values:
  - `log_wr_req_val`=0, `log_wr_req_data`=0.
  - State IDLE; all counters 0.
- RUN cycles are numbered from 0, starting at the entry edge.
- Record k (k≥1):
  - tick occurs in RUN cycle k·`SAMPLE_INTERVAL`-1.
  - `log_wr_req_val` is high exactly in RUN cycle k·`SAMPLE_INTERVAL`, for one cycle.
  - its timestamp is k·`SAMPLE_INTERVAL`-1.
- Latency from the final counted request to the record: 1 cycle (tick case).
- Reset asserted mid-RUN:
  - immediate return to IDLE with outputs 0.
  - a record that was asserted is dropped, not completed.

## Configuration
- `ECHO_APP_STATS_DELTA_EN` defined:
  - `req_cnt` is the number of requests in the interval just closed.
  - The counter clears to 0 at each tick edge.
  - A request in the tick cycle goes into the closing record, not the next one.
  - The first record also includes the entry request.
- Undefined: `req_cnt` is cumulative since RUN entry and never clears.
- Saturation applies per interval (delta) or globally (cumulative).

## Structure
- Package `echo_app_stats_defs` (shared with the log/reader) holds:
  - `echo_app_stats_struct` (`timestamp` [`STATS_TIMESTAMP_W`=64], `req_cnt` [`STATS_REQ_CNT_W`=64])
  - `ECHO_APP_STATS_STRUCT_W`
  - `STATS_DEPTH_LOG2`
  - `CLIENT_ADDR_W`
  - state enum `sampler_state_e` {IDLE, RUN}
- Sub-module `echo_app_stats_sat_ctr`:
  - parameter W.
  - inputs: `incr`, `clr`, `load1`.
  - saturating count; `clr` combined with `incr` yields 0 (delta tick semantics handled by the parent).
- Everything else lives in the parent: FSM, interval/timestamp counters, output register.

## Test plan
All scenarios use `SAMPLE_INTERVAL`=8 unless noted.
- Reset, no requests for 200 cycles → `log_wr_req_val` never asserted; outputs stay 0.
- One request, then silence → records at RUN cycles 8 and 16 with ts=7, cnt=1 and ts=15, cnt=1. Under DELTA_EN the second record has cnt=0.
- Request every cycle from entry → first record ts=7, cnt=9. Second record cnt=17 (cumulative) or cnt=8 (DELTA_EN).
- Single extra request exactly in tick cycle 15 (after entry request only) → record at cycle 16 has cnt=2 (cumulative) or 1 (DELTA_EN). The record at cycle 24 does not include it under DELTA_EN (cnt=0).
- `CNT_W`=3, requests every cycle → cnt saturates at 7 in every record (cumulative), and in each interval under DELTA_EN; never wraps to 0.
- Assert `rst` for 1 cycle in RUN cycle 8 while `log_wr_req_val`=1 → val drops asynchronously; no further records until a new request. After the next request, timestamps restart (first record ts=7).

Source files
------------

// File: rtl/echo_app_stats_sampler_pkg.sv
`default_nettype none
// ============================================================================
// echo_app_stats_defs : record layout and sampler state shared with the stats log/reader
// Rev 1.0
// ============================================================================
package echo_app_stats_defs;
  localparam int STATS_TIMESTAMP_W = 64;
  localparam int STATS_REQ_CNT_W   = 64;
  localparam int STATS_DEPTH_LOG2  = 10;
  localparam int CLIENT_ADDR_W     = 8;

  typedef struct packed {
    logic [STATS_TIMESTAMP_W-1:0] timestamp;
    logic [STATS_REQ_CNT_W-1:0]   req_cnt;
  } echo_app_stats_struct;

  localparam int ECHO_APP_STATS_STRUCT_W = $bits(echo_app_stats_struct);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sampler_state_e;
endpackage
`default_nettype wire

// File: rtl/echo_app_stats_sampler_sat_ctr.sv
`default_nettype none
// ============================================================================
// echo_app_stats_sat_ctr : saturating request counter with load-to-1 and clear
// Rev 1.0
// ============================================================================
module echo_app_stats_sat_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         incr,
  input  logic         clr,
  input  logic         load1,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_incr_o
);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // cnt_incr_o is the count with this cycle's request applied, so a closing
  // record can include a request that arrives in the tick cycle itself.
  always_comb begin
    cnt_incr_o = (incr && (cnt_q != CNT_MAX)) ? cnt_q + W'(1) : cnt_q;
    cnt_d      = cnt_incr_o;
    if (clr)   cnt_d = '0;
    if (load1) cnt_d = W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/echo_app_stats_sampler.sv
`default_nettype none
// ============================================================================
// echo_app_stats_sampler : periodic {timestamp, req_cnt} records into simple_log.
// Define ECHO_APP_STATS_DELTA_EN for per-interval counts (default: cumulative).
// Rev 1.0
// ============================================================================
module echo_app_stats_sampler
  import echo_app_stats_defs::*;
#(
  parameter longint unsigned SAMPLE_INTERVAL = 1024,
  parameter int              CNT_W           = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               echo_app_incr_req_done,
  output logic                               log_wr_req_val,
  output logic [ECHO_APP_STATS_STRUCT_W-1:0] log_wr_req_data
);
  if ((SAMPLE_INTERVAL < 2) || (SAMPLE_INTERVAL > 64'h0000_0000_FFFF_FFFF)) begin : g_bad_interval
    $error("SAMPLE_INTERVAL must be in 2..2^32-1");
  end
  if ((CNT_W < 1) || (CNT_W > STATS_REQ_CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..STATS_REQ_CNT_W");
  end

  localparam logic [31:0] INTERVAL_LAST = 32'(SAMPLE_INTERVAL - 1);

  sampler_state_e               state_q;
  logic [31:0]                  interval_cnt_q;
  logic [STATS_TIMESTAMP_W-1:0] timestamp_q;
  logic [CNT_W-1:0]             req_cnt_q;
  logic [CNT_W-1:0]             req_cnt_incr;
  logic                         tick;
  logic                         start;
  logic                         ctr_incr;
  logic                         ctr_clr;
  echo_app_stats_struct         rec;

  assign start    = (state_q == IDLE) && echo_app_incr_req_done;
  assign tick     = (state_q == RUN) && (interval_cnt_q == INTERVAL_LAST);
  assign ctr_incr = (state_q == RUN) && echo_app_incr_req_done;
`ifdef ECHO_APP_STATS_DELTA_EN
  assign ctr_clr  = tick;
`else
  assign ctr_clr  = 1'b0;
`endif

  echo_app_stats_sat_ctr #(
    .W(CNT_W)
  ) u_req_ctr (
    .clk       (clk),
    .rst       (rst),
    .incr      (ctr_incr),
    .clr       (ctr_clr),
    .load1     (start),
    .cnt_o     (req_cnt_q),
    .cnt_incr_o(req_cnt_incr)
  );

  always_comb begin
    rec.timestamp = timestamp_q;
    rec.req_cnt   = STATS_REQ_CNT_W'(req_cnt_incr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      interval_cnt_q  <= '0;
      timestamp_q     <= '0;
      log_wr_req_val  <= 1'b0;
      log_wr_req_data <= '0;
    end else begin
      log_wr_req_val <= 1'b0;
      case (state_q)
        IDLE: begin
          if (echo_app_incr_req_done) begin
            state_q        <= RUN;
            interval_cnt_q <= '0;
            timestamp_q    <= '0;
          end
        end
        RUN: begin
          timestamp_q    <= timestamp_q + 64'd1;
          interval_cnt_q <= tick ? 32'd0 : interval_cnt_q + 32'd1;
          if (tick) begin
            log_wr_req_val  <= 1'b1;
            log_wr_req_data <= rec;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_echo_app_stats_sampler.sv
`default_nettype none
// ============================================================================
// tb_echo_app_stats_sampler : directed scoreboard bench, SAMPLE_INTERVAL=8,
// one instance with CNT_W=32 (a) and one with CNT_W=3 (b). Rev 1.0
// ============================================================================
module tb_echo_app_stats_sampler;
  import echo_app_stats_defs::*;

`ifdef ECHO_APP_STATS_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  typedef struct {
    longint unsigned cyc;
    logic [63:0]     ts;
    logic [63:0]     cnt;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic val_a, val_b;
  logic [ECHO_APP_STATS_STRUCT_W-1:0] data_a, data_b;

  longint unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  rec_t q_a[$];
  rec_t q_b[$];
  longint unsigned p;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  echo_app_stats_sampler #(.SAMPLE_INTERVAL(8), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .echo_app_incr_req_done(req),
    .log_wr_req_val(val_a), .log_wr_req_data(data_a)
  );
  echo_app_stats_sampler #(.SAMPLE_INTERVAL(8), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .echo_app_incr_req_done(req),
    .log_wr_req_val(val_b), .log_wr_req_data(data_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input longint unsigned at, input longint unsigned ts,
                            input longint unsigned cnt_a, input longint unsigned cnt_b);
    rec_t r;
    r.cyc = at; r.ts = ts; r.cnt = cnt_a;
    q_a.push_back(r);
    r.cnt = cnt_b;
    q_b.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_pending_a"}, q_a.size(), 0);
    chk({tag, "_pending_b"}, q_b.size(), 0);
  endtask

  // Scoreboard: every record seen must be the next expected one, on its cycle.
  always @(negedge clk) begin
    rec_t e;
    if (val_a) begin
      if (q_a.size() == 0) chk("a_unexpected_val", val_a, 1'b0);
      else begin
        e = q_a.pop_front();
        chk("a_rec_cycle", cyc, e.cyc);
        chk("a_rec_ts", data_a[127:64], e.ts);
        chk("a_rec_cnt", data_a[63:0], e.cnt);
      end
    end
    if (val_b) begin
      if (q_b.size() == 0) chk("b_unexpected_val", val_b, 1'b0);
      else begin
        e = q_b.pop_front();
        chk("b_rec_cycle", cyc, e.cyc);
        chk("b_rec_ts", data_b[127:64], e.ts);
        chk("b_rec_cnt", data_b[63:0], e.cnt);
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) step();
    chk("rst_val_a", val_a, 1'b0);
    chk("rst_data_a", data_a, '0);
    chk("rst_val_b", val_b, 1'b0);
    chk("rst_data_b", data_b, '0);
    rst = 1'b0;

    // No requests: nothing is ever written
    repeat (200) step();
    chk("idle_val_a", val_a, 1'b0);
    chk("idle_data_a", data_a, '0);
    chk("idle_data_b", data_b, '0);

    // One request then silence
    do_reset();
    p = cyc;
    expect_rec(p + 9, 7, 1, 1);
    expect_rec(p + 17, 15, DELTA ? 0 : 1, DELTA ? 0 : 1);
    req = 1'b1; step(); req = 1'b0;
    repeat (19) step();
    chk_drained("one_req");

    // Request every cycle from entry; b saturates at 7
    do_reset();
    p = cyc;
    expect_rec(p + 9, 7, 9, 7);
    expect_rec(p + 17, 15, DELTA ? 8 : 17, 7);
    expect_rec(p + 25, 23, DELTA ? 8 : 25, 7);
    expect_rec(p + 33, 31, DELTA ? 0 : 25, DELTA ? 0 : 7);
    req = 1'b1;
    repeat (25) step();
    req = 1'b0;
    repeat (9) step();
    chk_drained("every_cycle");

    // Extra request exactly in the tick cycle 15
    do_reset();
    p = cyc;
    expect_rec(p + 9, 7, 1, 1);
    expect_rec(p + 17, 15, DELTA ? 1 : 2, DELTA ? 1 : 2);
    expect_rec(p + 25, 23, DELTA ? 0 : 2, DELTA ? 0 : 2);
    req = 1'b1; step(); req = 1'b0;
    repeat (15) step();
    req = 1'b1; step(); req = 1'b0;
    repeat (9) step();
    chk_drained("tick_req");

    // Reset while a record is on the port
    do_reset();
    p = cyc;
    expect_rec(p + 9, 7, 1, 1);
    req = 1'b1; step(); req = 1'b0;
    repeat (8) step();
    chk("mid_val_a_before_rst", val_a, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_val_a", val_a, 1'b0);
    chk("mid_rst_data_a", data_a, '0);
    chk("mid_rst_val_b", val_b, 1'b0);
    step();
    rst = 1'b0;
    repeat (20) step();
    chk_drained("post_rst_idle");
    p = cyc;
    expect_rec(p + 9, 7, 1, 1);
    req = 1'b1; step(); req = 1'b0;
    repeat (9) step();
    chk_drained("post_rst_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
